// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch stage (package if_pkg).
package if_pkg;

    localparam int          XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // Redirect targets are word addresses; the low bits are never honoured.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC register and next-PC mux: sequential +4, branch redirect, misaligned-target trap.
// Trap path is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_pc_gen
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_advance,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_target,
    output logic [XLEN-1:0] o_fetch_pc,
    output logic            o_trap
);

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_next_pc;
    logic            w_trap;

    assign w_trap = TRAP_EN && i_redirect && (i_target[1:0] != 2'b00);

    // Redirect outranks advance; the +4 wraps naturally at the XLEN boundary.
    always_comb begin
        w_next_pc = r_fetch_pc;
        if (w_trap) begin
            w_next_pc = TRAP_PC;
        end else if (i_redirect) begin
            w_next_pc = word_align(i_target);
        end else if (i_advance) begin
            w_next_pc = r_fetch_pc + XLEN'(INST_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
        end else begin
            r_fetch_pc <= w_next_pc;
        end
    end

    assign o_fetch_pc = r_fetch_pc;
    assign o_trap     = w_trap;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request, IF/ID valid/ready hand-off,
// branch redirect with flush and stale-response drop. Misaligned-target trap via FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branch_sel,
    input  logic [XLEN-1:0] branch_inp,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc_present,
    output logic            inst_valid,
    input  logic            id_ready,
    output logic            flush,
    output logic            misalign
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc_present;
    logic            r_inst_valid;
    logic            r_flush;
    logic            r_misalign;
    logic [XLEN-1:0] w_fetch_pc;
    logic            w_trap;
    logic            w_advance;
    logic            w_capture;
    logic            w_release;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC),
        .TRAP_PC  (TRAP_PC)
    ) u_pc_gen (
        .clk        (clk),
        .reset      (reset),
        .i_advance  (w_advance),
        .i_redirect (branch_sel),
        .i_target   (branch_inp),
        .o_fetch_pc (w_fetch_pc),
        .o_trap     (w_trap)
    );

    assign w_advance = (r_state == IDLE) && imem_gnt    && !branch_sel;
    assign w_capture = (r_state == WAIT) && imem_rvalid && !branch_sel;
    assign w_release = (r_state == HOLD) && id_ready;

    // A redirect overrides every other event; a grant or response caught by it is stale.
    always_comb begin
        w_state_nxt = r_state;
        if (branch_sel) begin
            case (r_state)
                IDLE:    w_state_nxt = imem_gnt    ? DROP : IDLE;
                WAIT:    w_state_nxt = imem_rvalid ? IDLE : DROP;
                DROP:    w_state_nxt = DROP;
                HOLD:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end else begin
            case (r_state)
                IDLE:    if (imem_gnt)    w_state_nxt = WAIT;
                WAIT:    if (imem_rvalid) w_state_nxt = HOLD;
                DROP:    if (imem_rvalid) w_state_nxt = IDLE;
                HOLD:    if (id_ready)    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_req_pc     <= RESET_PC;
            r_inst       <= NOP_INST;
            r_pc_present <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_flush      <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_flush    <= branch_sel;
            r_misalign <= w_trap;
            if (w_advance) begin
                r_req_pc <= w_fetch_pc;
            end
            if (w_capture) begin
                r_inst       <= imem_rdata;
                r_pc_present <= r_req_pc;
                r_inst_valid <= 1'b1;
            end else if (branch_sel || w_release) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    // Request is held low while reset is asserted so nothing is issued before the state is known.
    assign imem_req   = (r_state == IDLE) && !reset;
    assign imem_addr  = w_fetch_pc;
    assign inst       = r_inst;
    assign pc_present = r_pc_present;
    assign inst_valid = r_inst_valid;
    assign flush      = r_flush;
    assign misalign   = r_misalign;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: scripted memory responder plus a scoreboard of delivered instructions.
module tb_fetch_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_sel;
    logic [31:0] branch_inp;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc_present;
    logic        inst_valid;
    logic        id_ready;
    logic        flush;
    logic        misalign;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    exp_t        exp_q[$];

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_TGT = 32'h0000_0100;
    localparam logic        MIS_EXP = 1'b1;
`else
    localparam logic [31:0] MIS_TGT = 32'h0000_0020;
    localparam logic        MIS_EXP = 1'b0;
`endif

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .TRAP_PC  (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .branch_sel  (branch_sel),
        .branch_inp  (branch_inp),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .pc_present  (pc_present),
        .inst_valid  (inst_valid),
        .id_ready    (id_ready),
        .flush       (flush),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    // Scoreboard: every completed IF/ID transfer must match the next expected instruction.
    always @(negedge clk) begin
        if (!reset && inst_valid && id_ready && !branch_sel) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_transfer got pc=%h inst=%h want none", pc_present, inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (pc_present !== e.pc || inst !== e.inst) begin
                    bad++;
                    $display("FAIL transfer got pc=%h inst=%h want pc=%h inst=%h",
                             pc_present, inst, e.pc, e.inst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE: grant now, response next cycle, decode accepts in HOLD.
    task automatic fetch_one(input logic [31:0] a, input bit push);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== a) begin
            bad++;
            $display("FAIL fetch_req got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, a);
        end
        imem_gnt = 1'b1;
        if (push) exp_q.push_back('{pc: a, inst: mem(a)});
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = mem(a);
        step();
        imem_rvalid = 1'b0;
        total++;
        if (inst_valid !== 1'b1) begin
            bad++;
            $display("FAIL fetch_valid got %b want 1 (addr %h)", inst_valid, a);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; branch_sel = 1'b0; branch_inp = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b1;
        step(); step();
        total++;
        if (imem_req !== 1'b0 || inst !== 32'h0000_0013 || pc_present !== 32'h0 ||
            inst_valid !== 1'b0 || flush !== 1'b0 || misalign !== 1'b0 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_vals got req=%b inst=%h pc=%h v=%b fl=%b mis=%b addr=%h want 0 00000013 0 0 0 0 0",
                     imem_req, inst, pc_present, inst_valid, flush, misalign, imem_addr);
        end
        reset = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        total++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL idle_rvalid got v=%b req=%b addr=%h want 0 1 00000000", inst_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        int unsigned c0;
        c0 = cyc;
        fetch_one(32'h0, 1'b1);
        total++;
        if (inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_one_cycle got %b want 0", inst_valid);
        end
        fetch_one(32'h4, 1'b1);
        total++;
        if (cyc - c0 != 6) begin
            bad++;
            $display("FAIL cadence got %0d cycles want 6", cyc - c0);
        end
    endtask

    task automatic test_stall();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            bad++;
            $display("FAIL stall_req got req=%b addr=%h want 1 00000008", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        exp_q.push_back('{pc: 32'h8, inst: mem(32'h8)});
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem(32'h8); id_ready = 1'b0;
        step();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (inst_valid !== 1'b1 || inst !== mem(32'h8) || pc_present !== 32'h8 || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable got v=%b inst=%h pc=%h req=%b want 1 %h 00000008 0",
                         inst_valid, inst, pc_present, imem_req, mem(32'h8));
            end
            step();
        end
        id_ready = 1'b1;
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            bad++;
            $display("FAIL post_stall_req got req=%b addr=%h want 1 0000000c", imem_req, imem_addr);
        end
    endtask

    task automatic test_branch_wait();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; branch_sel = 1'b1; branch_inp = 32'd40;
        step();
        branch_sel = 1'b0;
        total++;
        if (flush !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL bw_drop got fl=%b req=%b v=%b want 1 0 0", flush, imem_req, inst_valid);
        end
        imem_rvalid = 1'b1; imem_rdata = mem(32'hC);
        step();
        imem_rvalid = 1'b0;
        total++;
        if (flush !== 1'b0 || inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd40) begin
            bad++;
            $display("FAIL bw_resume got fl=%b v=%b req=%b addr=%h want 0 0 1 00000028",
                     flush, inst_valid, imem_req, imem_addr);
        end
        fetch_one(32'd40, 1'b1);
    endtask

    task automatic test_branch_rvalid();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; branch_sel = 1'b1; branch_inp = 32'h80;
        imem_rvalid = 1'b1; imem_rdata = mem(32'd44);
        step();
        branch_sel = 1'b0; imem_rvalid = 1'b0;
        total++;
        if (flush !== 1'b1 || inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            bad++;
            $display("FAIL br_rvalid got fl=%b v=%b req=%b addr=%h want 1 0 1 00000080",
                     flush, inst_valid, imem_req, imem_addr);
        end
        fetch_one(32'h80, 1'b1);
    endtask

    task automatic test_branch_hold();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem(32'h84);
        step();
        imem_rvalid = 1'b0; branch_sel = 1'b1; branch_inp = 32'h22;
        step();
        branch_sel = 1'b0;
        total++;
        if (flush !== 1'b1 || misalign !== MIS_EXP || inst_valid !== 1'b0 || imem_addr !== MIS_TGT) begin
            bad++;
            $display("FAIL bh_redirect got fl=%b mis=%b v=%b addr=%h want 1 %b 0 %h",
                     flush, misalign, inst_valid, imem_addr, MIS_EXP, MIS_TGT);
        end
        step();
        total++;
        if (flush !== 1'b0 || misalign !== 1'b0) begin
            bad++;
            $display("FAIL bh_pulse got fl=%b mis=%b want 0 0", flush, misalign);
        end
        fetch_one(MIS_TGT, 1'b1);
    endtask

    task automatic test_branch_idle_drop();
        branch_sel = 1'b1; branch_inp = 32'h300;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== MIS_TGT + 32'h4) begin
            bad++;
            $display("FAIL bi_old_addr got req=%b addr=%h want 1 %h", imem_req, imem_addr, MIS_TGT + 32'h4);
        end
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            bad++;
            $display("FAIL bi_new_addr got req=%b addr=%h want 1 00000300", imem_req, imem_addr);
        end
        imem_gnt = 1'b1; branch_inp = 32'h400;
        step();
        imem_gnt = 1'b0; branch_inp = 32'h500;
        step();
        branch_sel = 1'b0;
        total++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h500) begin
            bad++;
            $display("FAIL drop_redirect got req=%b addr=%h want 0 00000500", imem_req, imem_addr);
        end
        imem_rvalid = 1'b1; imem_rdata = mem(32'h300);
        step();
        imem_rvalid = 1'b0;
        fetch_one(32'h500, 1'b1);
    endtask

    task automatic test_wrap();
        branch_sel = 1'b1; branch_inp = 32'hFFFF_FFFC;
        step();
        branch_sel = 1'b0;
        fetch_one(32'hFFFF_FFFC, 1'b1);
        total++;
        if (imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL wrap got addr=%h want 00000000", imem_addr);
        end
        fetch_one(32'h0, 1'b1);
    endtask

    task automatic test_reset_mid();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem(32'h4);
        step();
        imem_rvalid = 1'b0;
        total++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0 || inst !== 32'h0000_0013) begin
            bad++;
            $display("FAIL reset_mid got v=%b req=%b addr=%h inst=%h want 0 1 00000000 00000013",
                     inst_valid, imem_req, imem_addr, inst);
        end
        fetch_one(32'h0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_wait();
        test_branch_rvalid();
        test_branch_hold();
        test_branch_idle_drop();
        test_wrap();
        test_reset_mid();
        step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the instruction-fetch stage. It owns the fetch PC, issues one instruction-memory request at a time, and presents fetched instructions to decode with a valid/ready handshake. It applies branch redirects from execute, flushes IF/ID, and discards stale memory responses. It sits between the execute-stage branch outputs, instruction memory and the IF/ID boundary.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
TRAP_PC, 32'h0000_0100, redirect target for misaligned branch targets (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
branch_sel  in  1  redirect request from execute, single-cycle pulse
branch_inp  in  32  redirect target
imem_req  out  1  memory request valid
imem_addr  out  32  request address (= fetch_pc)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction
inst  out  32  instruction to decode
pc_present  out  32  PC of inst
inst_valid  out  1  inst/pc_present valid
id_ready  in  1  decode accepts this cycle
flush  out  1  IF/ID flush pulse
misalign  out  1  misaligned-target pulse (constant 0 when feature is off)

Behaviour:
- One clock. Reset is synchronous and active-high. Port names are clk and reset.
- Reset values: state=IDLE, fetch_pc=RESET_PC, imem_req=0, inst=32'h0000_0013 (NOP), pc_present=RESET_PC, inst_valid=0, flush=0, misalign=0. Reset mid-transaction abandons the outstanding request. An imem_rvalid arriving after reset, while in IDLE, is ignored.
- States: IDLE, WAIT, DROP, HOLD. At most one request is outstanding.
- IDLE: imem_req=1 and imem_addr=fetch_pc, both combinational. On imem_gnt, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4, and the state moves to WAIT.
- WAIT: imem_req=0. On imem_rvalid, inst<=imem_rdata, pc_present<=req_pc, inst_valid<=1, and the state moves to HOLD.
- HOLD: inst_valid=1 and outputs stay stable. When id_ready=1, the transfer completes, inst_valid<=0, and the state moves to IDLE.
- DROP: imem_req=0. On imem_rvalid, the data is discarded and the state moves to IDLE.
- Zero-wait memory gives a peak throughput of 1 instruction per 3 cycles.
- imem_rvalid is ignored in IDLE and HOLD.
- fetch_pc+4 wraps modulo 2^32: 32'hFFFF_FFFC goes to 32'h0.
- Redirect (branch_sel=1) has the highest priority over every other event in the same cycle:
  - fetch_pc<=branch_inp with bits [1:0] forced to 0.
  - flush<=1 for exactly one cycle.
  - inst_valid<=0.
- Redirect state transitions:
  - IDLE without imem_gnt: stay in IDLE. That cycle's request still carries the old address; it is withdrawn next cycle.
  - IDLE with imem_gnt: go to DROP, because the granted request is stale.
  - WAIT without imem_rvalid: go to DROP.
  - WAIT with imem_rvalid: the response is discarded and the state goes to IDLE.
  - HOLD: go to IDLE. The held instruction is dropped even if id_ready=1.
  - DROP: stay in DROP, with fetch_pc updated.
- Redirect latency: the first request to the new target is presented no later than 1 cycle after the redirect, or 1 cycle after the stale response when in DROP.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: if branch_sel=1 and branch_inp[1:0]!=0, then fetch_pc<=TRAP_PC, misalign pulses 1 for one cycle, and flush pulses as for a normal redirect.
- Undefined: target bits [1:0] are silently cleared, misalign is tied to 0, and TRAP_PC is unused.

Decomposition:
- Package if_pkg:
  - fetch_state_t enum {IDLE, WAIT, DROP, HOLD}
  - NOP_INST = 32'h0000_0013
  - INST_BYTES = 4
  - XLEN = 32
- Sub-module fetch_pc_gen holds the fetch_pc register and next-PC mux (sequential +4, redirect, trap). It takes advance and redirect strobes from the FSM.

Test Plan:
- Reset release, zero-wait memory (gnt same cycle, rvalid next), id_ready=1 -> imem_addr sequence 0,4,8. Each inst_valid is 1 for one cycle with pc_present 0,4,8. inst_valid rises every 3 cycles.
- id_ready=0 for 4 cycles during HOLD at pc 8 -> inst and pc_present stable, no imem_req. Release -> request to 12 in the next cycle.
- branch_sel=1, branch_inp=40 while in WAIT for address 12 -> flush pulses once and the state enters DROP. The response for 12 never appears on inst. The next imem_addr=40 and pc_present=40.
- branch_sel coinciding with imem_rvalid in WAIT, target 32'h80 -> data discarded, no inst_valid. The next request is 32'h80 one cycle later.
- Fetch from 32'hFFFF_FFFC -> the following request address is 32'h0.
- With FETCH_MISALIGN_TRAP_EN: branch_inp=32'h22 -> misalign=1 and flush=1 for one cycle, and the next imem_addr=32'h100. Without the macro: the next imem_addr=32'h20 and misalign stays 0.
